// File: rtl/puf_pkg.sv
// Shared constants and FSM encoding for the arbiter-PUF response collector.
package puf_pkg;

  localparam int DEF_NUM_PUF       = 4;
  localparam int DEF_RESP_WIDTH    = 8;
  localparam int DEF_SETTLE_CYCLES = 4;

  // Wide enough for the full legal SETTLE_CYCLES range (1..255).
  localparam int SETTLE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SETTLE,
    ST_SAMPLE,
    ST_OUTPUT
  } state_t;

endpackage

// File: rtl/resp_shift_xor.sv
// XOR-reduces the parallel arbiter outputs into one response bit and inserts it
// into the response word at the position given by the bit counter.
module resp_shift_xor #(
  parameter int NUM_PUF    = 4,
  parameter int RESP_WIDTH = 8,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample,
  input  logic [CNT_W-1:0]      bit_idx,
  input  logic [NUM_PUF-1:0]    arb_out,
  output logic [RESP_WIDTH-1:0] resp_data
);

  logic                  resp_bit;
  logic [RESP_WIDTH-1:0] data_next;

  assign resp_bit = ^arb_out;

  // The previous word stays visible until the first bit of the next word lands;
  // the upper bits are cleared at that same moment.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    data_next = resp_data;
    if (bit_idx == '0) begin
      data_next = '0;
    end
    for (int i = 0; i < RESP_WIDTH; i++) begin
      if (int'(bit_idx) == i) begin
        data_next[i] = resp_bit;
      end
    end
  end

  // NOTE: the word register is observable at the port and must read 0 out of
  // reset, so it is reset like any control flop rather than left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data <= '0;
    end else if (sample) begin
      resp_data <= data_next;
    end
  end

endmodule

// File: rtl/response_collector.sv
// Sequences launch/settle/sample for each response bit of an XOR arbiter PUF
// and hands the packed word to a consumer over a valid/ready handshake.
module response_collector
  import puf_pkg::*;
#(
  parameter int NUM_PUF       = DEF_NUM_PUF,
  parameter int RESP_WIDTH    = DEF_RESP_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_PUF-1:0]    arb_out,
  output logic                  eval,
  output logic                  chal_next,
  output logic [RESP_WIDTH-1:0] resp_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  busy
);

  localparam int                 CNT_W       = $clog2(RESP_WIDTH);
  localparam logic [CNT_W-1:0]   LAST_BIT    = CNT_W'(RESP_WIDTH - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [SETTLE_W-1:0] settle_cnt, settle_cnt_n;
  logic                sample;
  logic                chal_n;

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    settle_cnt_n = settle_cnt;
    sample       = 1'b0;
    chal_n       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n   = ST_LAUNCH;
          bit_cnt_n = '0;
        end
      end
      ST_LAUNCH: begin
        state_n      = ST_SETTLE;
        settle_cnt_n = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          state_n = ST_SAMPLE;
          // Registered pulse must be high during SAMPLE when more bits follow.
          chal_n  = (bit_cnt != LAST_BIT);
        end else begin
          settle_cnt_n = settle_cnt - 1'b1;
        end
      end
      ST_SAMPLE: begin
        sample = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_n = '0;
          state_n   = ST_OUTPUT;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          state_n   = ST_LAUNCH;
        end
      end
      ST_OUTPUT: begin
        if (resp_ready) begin
          state_n = ST_IDLE;
          // Handshake depends on the live ready input, so the advance pulse is
          // registered and lands in the first IDLE cycle.
          chal_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      eval       <= 1'b0;
      chal_next  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      settle_cnt <= settle_cnt_n;
      eval       <= (state_n == ST_LAUNCH);
      chal_next  <= chal_n;
      resp_valid <= (state_n == ST_OUTPUT);
    end
  end

  assign busy = (state != ST_IDLE);

  resp_shift_xor #(
    .NUM_PUF   (NUM_PUF),
    .RESP_WIDTH(RESP_WIDTH),
    .CNT_W     (CNT_W)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample   (sample),
    .bit_idx  (bit_cnt),
    .arb_out  (arb_out),
    .resp_data(resp_data)
  );

endmodule

// File: tb/tb_response_collector.sv
// Scoreboard bench: parity model per evaluation feeds an expected-word queue,
// a negedge monitor checks every handshake, hold and latency.
module tb_response_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       resp_ready = 1'b0;
  logic [3:0] arb_out = '0;
  logic       eval, chal_next, resp_valid, busy;
  logic [7:0] resp_data;

  logic       s_start = 1'b0;
  logic       s_ready = 1'b0;
  logic [3:0] s_arb = '0;
  logic       s_eval, s_chal, s_valid, s_busy;
  logic [1:0] s_data;

  response_collector dut (
    .clk(clk), .rst_n(rst_n), .start(start), .arb_out(arb_out), .eval(eval),
    .chal_next(chal_next), .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .busy(busy)
  );

  response_collector #(.NUM_PUF(4), .RESP_WIDTH(2), .SETTLE_CYCLES(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .arb_out(s_arb), .eval(s_eval),
    .chal_next(s_chal), .resp_data(s_data), .resp_valid(s_valid),
    .resp_ready(s_ready), .busy(s_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int eval_cnt = 0, chal_cnt = 0, words_seen = 0;
  int t_start = 0;
  int mode = 0;
  logic [7:0] last_word = '0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: each evaluation contributes the parity of the applied
  // arbiter vector, LSB first; a complete word goes to the scoreboard.
  int bit_pos = 0;
  logic [7:0] exp_word = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bit_pos  = 0;
      exp_word = '0;
    end else if (eval) begin
      case (mode)
        0:       arb_out = 4'b0111;
        1:       arb_out = (bit_pos % 2 == 0) ? 4'b0001 : 4'b0011;
        default: arb_out = 4'($urandom);
      endcase
      exp_word[bit_pos] = ($countones(arb_out) % 2) == 1;
      bit_pos++;
      if (bit_pos == 8) begin
        exp_q.push_back(exp_word);
        bit_pos  = 0;
        exp_word = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (eval)      eval_cnt++;
    if (chal_next) chal_cnt++;
  end

  // Monitor
  logic prev_hold = 1'b0, prev_hs = 1'b0, prev_valid = 1'b0;
  logic [7:0] held = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold  = 1'b0;
      prev_hs    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_hs) check("valid_drop_after_hs", 32'(resp_valid), 32'd0);
      if (resp_valid && !prev_valid) check("latency", 32'(cyc - t_start), 32'd49);
      if (resp_valid) begin
        if (prev_hold) check("hold_data", 32'(resp_data), 32'(held));
        if (resp_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h expected none", resp_data);
          end else begin
            check("word", 32'(resp_data), 32'(exp_q.pop_front()));
          end
          last_word = resp_data;
          words_seen++;
        end
      end
      prev_hold  = resp_valid && !resp_ready;
      prev_hs    = resp_valid && resp_ready;
      prev_valid = resp_valid;
      held       = resp_data;
    end
  end

  // Small instance driver: wrong parity in the eval cycle, target parity from
  // the following cycle on, so only a post-eval sample yields the target.
  logic [1:0] s_target = '0;
  int s_pos = 0;
  logic s_pend = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_pos  = 0;
      s_pend = 1'b0;
    end else begin
      if (s_pend) begin
        s_arb = 4'($urandom);
        if ((($countones(s_arb) % 2) == 1) != s_target[s_pos]) s_arb[0] = ~s_arb[0];
        s_pend = 1'b0;
        s_pos  = (s_pos + 1) % 2;
      end
      if (s_eval) begin
        s_arb = 4'($urandom);
        if ((($countones(s_arb) % 2) == 1) == s_target[s_pos]) s_arb[0] = ~s_arb[0];
        s_pend = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_start();
    start   = 1'b1;
    t_start = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_word(input string name, input int budget, input bit rand_ready);
    int w0 = words_seen;
    int i;
    for (i = 0; i < budget; i++) begin
      if (words_seen != w0) break;
      if (rand_ready) resp_ready = 1'($urandom);
      tick(1);
    end
    if (words_seen == w0) check({name, "_timeout"}, 32'd0, 32'd1);
    resp_ready = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (resp_valid) break;
      tick(1);
    end
    check({name, "_valid"}, 32'(resp_valid), 32'd1);
  endtask

  initial begin
    int e0, c0, w0;
    tick(3);
    check("rst_eval", 32'(eval), 0);
    check("rst_chal", 32'(chal_next), 0);
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(resp_data), 0);
    rst_n = 1'b1;
    tick(2);

    // Constant 0111 -> all ones, counts of eval and chal_next pulses.
    mode = 0; resp_ready = 1'b1;
    e0 = eval_cnt; c0 = chal_cnt;
    issue_start();
    check("busy_after_start", 32'(busy), 1);
    wait_word("t1", 200, 0);
    tick(3);
    check("t1_word", 32'(last_word), 32'hFF);
    check("t1_evals", 32'(eval_cnt - e0), 8);
    check("t1_chals", 32'(chal_cnt - c0), 8);
    check("t1_idle", 32'(busy), 0);
    check("t1_retain", 32'(resp_data), 32'hFF);

    // Alternating odd/even parity -> 0x55.
    mode = 1;
    issue_start();
    wait_word("t2", 200, 0);
    tick(2);
    check("t2_word", 32'(last_word), 32'h55);

    // Back-pressure for 10 cycles; monitor checks hold each cycle.
    mode = 2; resp_ready = 1'b0;
    issue_start();
    wait_valid("t3", 200);
    tick(10);
    check("t3_still_valid", 32'(resp_valid), 1);
    resp_ready = 1'b1;
    wait_word("t3", 5, 0);
    tick(2);

    // Extra start in SETTLE and together with the handshake.
    resp_ready = 1'b0;
    e0 = eval_cnt; w0 = words_seen;
    issue_start();
    tick(2);
    start = 1'b1; tick(1); start = 1'b0;
    wait_valid("t4", 200);
    start = 1'b1; resp_ready = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    check("t4_evals", 32'(eval_cnt - e0), 8);
    check("t4_words", 32'(words_seen - w0), 1);
    check("t4_idle", 32'(busy), 0);
    check("t4_queue_empty", 32'(exp_q.size()), 0);

    // Random words with random back-pressure.
    for (int k = 0; k < 4; k++) begin
      issue_start();
      wait_word("t5", 400, 1);
      tick(2);
    end

    // Reset in SETTLE of bit 3, then a fresh full word.
    mode = 2; resp_ready = 1'b1;
    issue_start();
    tick(20);
    check("t6_in_settle_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_eval", 32'(eval), 0);
    check("t6_chal", 32'(chal_next), 0);
    check("t6_valid", 32'(resp_valid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_data", 32'(resp_data), 0);
    tick(1);
    rst_n = 1'b1;
    e0 = eval_cnt;
    issue_start();
    wait_word("t6", 200, 0);
    tick(2);
    check("t6_evals", 32'(eval_cnt - e0), 8);

    // Small instance: SETTLE_CYCLES=1, RESP_WIDTH=2.
    for (int k = 0; k < 3; k++) begin
      int t0;
      s_target = 2'($urandom);
      s_ready  = 1'b1;
      s_start  = 1'b1;
      t0 = cyc;
      tick(1);
      s_start = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (s_valid) break;
        tick(1);
      end
      check("small_latency", 32'(cyc - t0), 7);
      check("small_word", 32'(s_data), 32'(s_target));
      tick(1);
      check("small_valid_drop", 32'(s_valid), 0);
      tick(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
